// File: rtl/fifo_controller_pkg.sv
// Shared definitions for the transmit-layer FIFOs.
//   - fifo_depth(): depth of a FIFO from its pointer width (2**address_width)
//   - DEFAULT_*   : default geometry and occupancy thresholds
package fifo_controller_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 6;
  localparam int DEFAULT_ADDRESS_WIDTH   = 3;
  localparam int DEFAULT_ALMOST_FULL_TH  = 6;
  localparam int DEFAULT_ALMOST_EMPTY_TH = 2;

  // Number of words addressable by a pointer of the given width.
  function automatic int fifo_depth(input int aw);
    return 32'sd2 ** aw;
  endfunction

endpackage

// File: rtl/fifo_controller_memoria.sv
// memoria: dual-port FIFO storage.
//   clk           : clock, all activity on posedge
//   wr_enable     : write FIFO_data_in into location wr_ptr
//   rd_enable     : load location rd_ptr into the read register
//   wr_ptr/rd_ptr : write / read addresses
//   FIFO_data_in  : write data
//   FIFO_data_out : registered read data, holds between reads
// Contents are never cleared. A read and a write to the same address on the
// same edge returns the old word (read-before-write).
module memoria
  import fifo_controller_pkg::*;
#(
  parameter int data_width    = DEFAULT_DATA_WIDTH,
  parameter int address_width = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     wr_enable,
  input  logic                     rd_enable,
  input  logic [address_width-1:0] wr_ptr,
  input  logic [address_width-1:0] rd_ptr,
  input  logic [data_width-1:0]    FIFO_data_in,
  output logic [data_width-1:0]    FIFO_data_out
);

  localparam int DEPTH = fifo_depth(address_width);

  logic [data_width-1:0] mem_r [DEPTH];
  logic [data_width-1:0] rd_data_r;

  // Storage write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_enable) begin
      mem_r[wr_ptr] <= FIFO_data_in;
    end
    if (rd_enable) begin
      rd_data_r <= mem_r[rd_ptr];
    end
  end

  assign FIFO_data_out = rd_data_r;

endmodule

// File: rtl/fifo_controller.sv
// fifo_controller: pointer, occupancy and flag controller driving memoria.
//   clk, reset       : clock and synchronous active-high reset
//   push, data_in    : write request and its data
//   pop              : read request
//   data_out         : read data, holds its value while valid_out is low
//   valid_out        : one-cycle pulse per accepted pop, one cycle after the
//                      memory read
//   full/empty       : count == depth / count == 0
//   almost_full      : count >= almost_full_th
//   almost_empty     : count <= almost_empty_th
//   overflow_err     : sticky, push while full without a pop
//   underflow_err    : sticky, pop while empty
//   fifo_count       : occupancy 0..depth
module fifo_controller
  import fifo_controller_pkg::*;
#(
  parameter int data_width      = DEFAULT_DATA_WIDTH,
  parameter int address_width   = DEFAULT_ADDRESS_WIDTH,
  parameter int almost_full_th  = DEFAULT_ALMOST_FULL_TH,
  parameter int almost_empty_th = DEFAULT_ALMOST_EMPTY_TH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [data_width-1:0] data_in,
  output logic [data_width-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic [address_width:0] fifo_count
);

  localparam int CNT_W = address_width + 1;
  localparam int PTR_W = address_width;
  localparam logic [address_width:0]   DEPTH_C   = CNT_W'(fifo_depth(address_width));
  localparam logic [address_width:0]   AF_TH_C   = CNT_W'(almost_full_th);
  localparam logic [address_width:0]   AE_TH_C   = CNT_W'(almost_empty_th);
  localparam logic [address_width:0]   CNT_ONE_C = CNT_W'(1'b1);
  localparam logic [address_width-1:0] PTR_ONE_C = PTR_W'(1'b1);

  logic [address_width-1:0] wr_ptr_r;
  logic [address_width-1:0] rd_ptr_r;
  logic [address_width:0]   count_r;
  logic                     full_r;
  logic                     empty_r;
  logic                     almost_full_r;
  logic                     almost_empty_r;
  logic                     overflow_r;
  logic                     underflow_r;
  logic                     rd_pending_r;
  logic                     valid_out_r;
  logic [data_width-1:0]    data_out_r;

  logic                     push_accept_s;
  logic                     pop_accept_s;
  logic                     overflow_s;
  logic                     underflow_s;
  logic [address_width:0]   count_next_s;
  logic                     wr_enable_s;
  logic                     rd_enable_s;
  logic [data_width-1:0]    mem_rdata_s;

  // Accept/reject decisions and the occupancy the next edge will load.
  // A push into a full FIFO is still accepted when a pop frees a slot in the
  // same cycle; a pop on an empty FIFO is never accepted (no bypass).
  always_comb begin
    push_accept_s = 1'b0;
    pop_accept_s  = 1'b0;
    overflow_s    = 1'b0;
    underflow_s   = 1'b0;
    count_next_s  = count_r;
    if (push && (!full_r || pop)) begin
      push_accept_s = 1'b1;
    end else begin
      push_accept_s = 1'b0;
    end
    if (pop && !empty_r) begin
      pop_accept_s = 1'b1;
    end else begin
      pop_accept_s = 1'b0;
    end
    if (push && full_r && !pop) begin
      overflow_s = 1'b1;
    end else begin
      overflow_s = 1'b0;
    end
    if (pop && empty_r) begin
      underflow_s = 1'b1;
    end else begin
      underflow_s = 1'b0;
    end
    case ({push_accept_s, pop_accept_s})
      2'b10:   count_next_s = count_r + CNT_ONE_C;
      2'b01:   count_next_s = count_r - CNT_ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // Reset takes priority over a same-cycle push/pop, so memory is gated too.
  assign wr_enable_s = push_accept_s & ~reset;
  assign rd_enable_s = pop_accept_s & ~reset;

  // Read and write pointers, wrapping naturally at the pointer width.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_accept_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
    end
  end

  // Occupancy, threshold flags from the next count, and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r        <= '0;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      count_r        <= count_next_s;
      full_r         <= (count_next_s == DEPTH_C);
      empty_r        <= (count_next_s == '0);
      almost_full_r  <= (count_next_s >= AF_TH_C);
      almost_empty_r <= (count_next_s <= AE_TH_C);
      overflow_r     <= overflow_r | overflow_s;
      underflow_r    <= underflow_r | underflow_s;
    end
  end

  // Read pipeline: memory register loads on the pop edge, data_out/valid_out
  // follow on the next edge; data_out only changes when a word arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending_r <= 1'b0;
      valid_out_r  <= 1'b0;
      data_out_r   <= '0;
    end else begin
      rd_pending_r <= pop_accept_s;
      valid_out_r  <= rd_pending_r;
      if (rd_pending_r) begin
        data_out_r <= mem_rdata_s;
      end
    end
  end

  memoria #(
    .data_width    (data_width),
    .address_width (address_width)
  ) u_memoria (
    .clk           (clk),
    .wr_enable     (wr_enable_s),
    .rd_enable     (rd_enable_s),
    .wr_ptr        (wr_ptr_r),
    .rd_ptr        (rd_ptr_r),
    .FIFO_data_in  (data_in),
    .FIFO_data_out (mem_rdata_s)
  );

  assign data_out      = data_out_r;
  assign valid_out     = valid_out_r;
  assign full          = full_r;
  assign empty         = empty_r;
  assign almost_full   = almost_full_r;
  assign almost_empty  = almost_empty_r;
  assign overflow_err  = overflow_r;
  assign underflow_err = underflow_r;
  assign fifo_count    = count_r;

endmodule

// File: doc/fifo_controller.md
# fifo_controller

Pointer and flag controller for the FIFO memory, acting as its driver: it generates `wr_ptr`/`rd_ptr`, `wr_enable`/`rd_enable` from push/pop requests and instantiates the memory. It tracks occupancy, raises full/empty/almost thresholds and sticky error flags, and presents read data with a one-cycle-latency valid strobe. It sits between the upstream producer and the downstream consumer of each PCIe transmit-layer FIFO.

## Interface
- `data_width`, 6, word width in bits
- `address_width`, 3, pointer width; depth = 2**address_width (8)
- `almost_full_th`, 6, almost_full asserted when count >= this
- `almost_empty_th`, 2, almost_empty asserted when count <= this

- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `push`  in  1  write request
- `pop`  in  1  read request
- `data_in`  in  data_width  write data, sampled with accepted push
- `data_out`  out  data_width  read data
- `valid_out`  out  1  data_out carries a newly popped word this cycle
- `full`  out  1  count == depth
- `empty`  out  1  count == 0
- `almost_full`  out  1  count >= almost_full_th
- `almost_empty`  out  1  count <= almost_empty_th
- `overflow_err`  out  1  sticky: push seen while full and no pop
- `underflow_err`  out  1  sticky: pop seen while empty
- `fifo_count`  out  address_width+1  current occupancy, 0..depth

## Operation
- Accepted push: `push && (!full || pop)`; writes `data_in` at `wr_ptr`, `wr_ptr` increments.
- Accepted pop: `pop && !empty`; reads at `rd_ptr`, `rd_ptr` increments.
- Pointers wrap modulo depth (7 -> 0), no extra wrap bit; full/empty derive from `fifo_count`.
- Count update: +1 push only, -1 pop only, unchanged for both or neither.
- Push+pop while full: both accepted, count stays depth, no overflow.
- Push+pop while empty: push accepted, pop rejected, `underflow_err` set; no write-through bypass.
- Rejected push: memory untouched, pointer unchanged, `overflow_err` set.
- Error flags stay high until reset.
- Flags are registered and updated with count in the same edge.

## Timing
- Reset (synchronous, checked on posedge): pointers, `fifo_count`, `data_out`, `valid_out`, error flags = 0; `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0. Memory contents are not cleared.
- Reset asserted mid-operation wins over same-cycle push/pop; both are dropped.
- Write: word is readable from the cycle after the accepted push.
- Read latency 1: pop accepted at edge N, `data_out`/`valid_out` = 1 after edge N+1; `valid_out` is a one-cycle pulse per accepted pop.
- `data_out` holds its last value while `valid_out` = 0.
- Back-to-back pops produce consecutive words, one per cycle.

## Structure
- Shared package holds the depth derivation (`2**address_width`) and default thresholds, reused by the other FIFOs in the transmit layer.
- One sub-module: `memoria` (existing dual-port memory), with `wr_enable`, `rd_enable`, `wr_ptr`, `rd_ptr`, `FIFO_data_in`, `FIFO_data_out`, synchronous write and registered read.
- Controller RTL covers pointer regs, count, flag regs, error regs and `valid_out` pipeline.

## Test plan
- Reset then idle 4 cycles -> `empty`=1, `almost_empty`=1, `fifo_count`=0, `data_out`=0, all errors 0.
- Push 0x15,0x3F,0x0B,0x3C,0x21,0x15,0x3F,0x00 on consecutive cycles -> `fifo_count` 1..8; `almost_full` rises at count 6; `full` at 8; `wr_ptr` wraps to 0.
- Push 0x39 while full, no pop -> `overflow_err`=1, count stays 8; then 8 pops -> `data_out` 0x15,0x3F,0x0B,0x3C,0x21,0x15,0x3F,0x00 each one cycle after pop with `valid_out` pulses; `empty`=1.
- Pop while empty -> `underflow_err`=1, `valid_out`=0, `rd_ptr` unchanged; push+pop on empty -> count becomes 1, `underflow_err` remains 1.
- Full FIFO, push 0x2A + pop same cycle -> count stays 8, popped word is oldest entry; 0x2A emerges last after 8 further pops.
- Fill to 5, assert reset with push=1 -> next cycle count=0, `empty`=1, errors cleared, push dropped.
